wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: LANES, default 4, number of 16-bit vector lanes written back (legal values 2, 4, 8).
REQ-002 clk  in  1  pipeline clock; all state updates on posedge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 x_valid  in  1  exec stage presents a valid instruction this cycle.
REQ-005 x_pc  in  16  exec instruction PC.
REQ-006 x_rt  in  4  destination register index.
REQ-007 x_result  in  16  scalar ALU/mov result.
REQ-008 x_vresult  in  16*LANES  vector result, lane 0 in bits [15:0].
REQ-009 x_isLd, x_is_vector_op, x_isHalt, x_writes_rt  in  1 each  instruction class flags.
REQ-010 x_taken  in  1  branch/jump resolved taken; x_target  in  16  redirect target.
REQ-011 mem_rdata  in  16  data-memory read data, valid 1 cycle after exec presented x_read_mem_addr.
REQ-012 x_stall  out  1  exec must hold all x_* inputs stable.
REQ-013 flush  out  1  one-cycle pulse squashing fetch/decode/exec; redirect_pc  out  16  new PC, valid while flush=1.
REQ-014 reg_wen  out  1; reg_widx  out  4; reg_wdata  out  16  scalar register-file write port.
REQ-015 vreg_wen  out  1; vreg_widx  out  4; vreg_lane  out  log2(LANES); vreg_wdata  out  16  vector register-file lane write port.
REQ-016 halted  out  1  sticky halt indication.

Function
REQ-017 Accept = x_valid & ~x_stall sampled at posedge; accepted fields are captured into WB registers (r_*).
REQ-018 States SHALL be RUN, VEC, HALT.
REQ-019 RUN, accepted scalar with x_writes_rt: next cycle reg_wen=1, reg_widx=r_rt, reg_wdata = r_isLd ? mem_rdata : r_result (combinational from r_* and mem_rdata).
REQ-020 RUN, accepted x_taken: next cycle flush=1 and redirect_pc=r_target for exactly one cycle; an x_valid present in that flush cycle SHALL NOT be accepted.
REQ-021 RUN, accepted x_is_vector_op: enter VEC with lane counter 0; each VEC cycle vreg_wen=1, vreg_widx=r_rt, vreg_lane=counter, vreg_wdata=lane[counter] of r_vresult; counter increments by 1.
REQ-022 VEC: x_stall = (counter != LANES-1); on counter == LANES-1 return to RUN, and an instruction accepted at that same edge SHALL write back normally the following cycle (no bubble).
REQ-023 RUN, accepted x_isHalt: enter HALT; halted=1 and x_stall=1 from the next cycle until reset; no register write for halt.
REQ-024 Priority when flags coincide on one accepted instruction: x_isHalt > x_taken > x_is_vector_op > scalar; lower-priority effects are dropped.
REQ-025 Write ports are mutually exclusive: reg_wen and vreg_wen never both 1.
REQ-026 With no accepted instruction, all write enables and flush SHALL be 0 the following cycle.

Reset
REQ-027 rst_n low: state=RUN, counter=0, r_valid=0; outputs x_stall, flush, reg_wen, vreg_wen, halted = 0; redirect_pc, reg_widx, reg_wdata, vreg_* = 0.
REQ-028 Reset mid-VEC or in HALT SHALL abort immediately with no further lane writes after rst_n rises.

Configuration
REQ-029 Macro WB_FWD_EN: when defined, add outputs fwd_valid(1), fwd_idx(4), fwd_data(16) mirroring reg_wen/reg_widx/reg_wdata combinationally for exec bypass; when undefined, these ports SHALL NOT exist.

Verification
REQ-030 Scalar: x_result=0x1234, x_rt=3, x_writes_rt=1 -> next cycle reg_wen=1, reg_widx=3, reg_wdata=0x1234.
REQ-031 Load: x_isLd=1, x_rt=5, mem_rdata=0xBEEF next cycle -> reg_wdata=0xBEEF, reg_widx=5.
REQ-032 Vector LANES=4, x_vresult=0x4444_3333_2222_1111, x_rt=2 -> vreg_wen for 4 cycles, lanes 0..3, data 0x1111..0x4444; x_stall high for the first 3 VEC cycles.
REQ-033 Branch: x_taken=1, x_target=0x0040 -> flush=1 and redirect_pc=0x0040 for one cycle; following x_valid ignored that cycle.
REQ-034 Halt then rst_n pulse low mid-HALT -> halted=1, x_stall=1 until reset; all outputs 0 immediately on reset assertion.

Source files
------------

// File: rtl/wb_stage_if.sv
// Writeback-stage bundle: exec-side instruction fields in, register-file write ports and control out.
// Latency: n/a (wiring only); the master drives x_*/mem_rdata, the slave drives everything else.
// Backpressure: x_stall from the slave tells the master to hold every x_* field stable.
// Optional WB_FWD_EN adds the fwd_* bypass mirror of the scalar write port.
interface wb_stage_if #(parameter int LANES = 4);
    localparam int LW = $clog2(LANES);

    logic                   x_valid;
    logic [15:0]            x_pc;
    logic [3:0]             x_rt;
    logic [15:0]            x_result;
    logic [16*LANES-1:0]    x_vresult;
    logic                   x_isLd;
    logic                   x_is_vector_op;
    logic                   x_isHalt;
    logic                   x_writes_rt;
    logic                   x_taken;
    logic [15:0]            x_target;
    logic [15:0]            mem_rdata;

    logic                   x_stall;
    logic                   flush;
    logic [15:0]            redirect_pc;
    logic                   reg_wen;
    logic [3:0]             reg_widx;
    logic [15:0]            reg_wdata;
    logic                   vreg_wen;
    logic [3:0]             vreg_widx;
    logic [LW-1:0]          vreg_lane;
    logic [15:0]            vreg_wdata;
    logic                   halted;
`ifdef WB_FWD_EN
    logic                   fwd_valid;
    logic [3:0]             fwd_idx;
    logic [15:0]            fwd_data;
`endif

    modport master (
`ifdef WB_FWD_EN
        input  fwd_valid, fwd_idx, fwd_data,
`endif
        output x_valid, x_pc, x_rt, x_result, x_vresult, x_isLd, x_is_vector_op,
               x_isHalt, x_writes_rt, x_taken, x_target, mem_rdata,
        input  x_stall, flush, redirect_pc, reg_wen, reg_widx, reg_wdata,
               vreg_wen, vreg_widx, vreg_lane, vreg_wdata, halted
    );

    modport slave (
`ifdef WB_FWD_EN
        output fwd_valid, fwd_idx, fwd_data,
`endif
        input  x_valid, x_pc, x_rt, x_result, x_vresult, x_isLd, x_is_vector_op,
               x_isHalt, x_writes_rt, x_taken, x_target, mem_rdata,
        output x_stall, flush, redirect_pc, reg_wen, reg_widx, reg_wdata,
               vreg_wen, vreg_widx, vreg_lane, vreg_wdata, halted
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: scalar/load writes, branch redirect flush, per-lane vector writeback, sticky halt.
// Latency: effects appear the cycle after accept; a vector op occupies LANES cycles, one lane per cycle.
// Backpressure: x_stall high during all but the last vector lane and forever in HALT; WB_FWD_EN adds fwd_* bypass.
module wb_stage #(
    parameter int LANES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_stage_if.slave   bus
);
    localparam int            LW   = $clog2(LANES);
    localparam logic [LW-1:0] LAST = LW'(LANES - 1);

    typedef enum logic [1:0] {RUN, VEC, HALT} state_t;

    state_t                 r_state, w_state_nxt;
    logic [LW-1:0]          r_cnt, w_cnt_nxt;

    // Captured instruction; r_br/r_wr hold the priority-resolved class so dropped effects never reach outputs.
    logic                   r_valid;
    logic                   r_br;
    logic                   r_wr;
    logic                   r_isLd;
    logic [3:0]             r_rt;
    logic [15:0]            r_result;
    logic [15:0]            r_target;
    logic [16*LANES-1:0]    r_vresult;

    logic                   w_stall;
    logic                   w_flush;
    logic                   w_acc;
    logic                   w_vec;
    logic                   w_reg_wen;
    logic [3:0]             w_reg_widx;
    logic [15:0]            w_reg_wdata;
    logic [15:0]            w_lane_dat;

    assign w_stall = (r_state == HALT) || ((r_state == VEC) && (r_cnt != LAST));
    assign w_flush = r_valid & r_br;
    // The instruction sitting in exec during a flush cycle is on the squashed path, so it is never taken.
    assign w_acc   = bus.x_valid & ~w_stall & ~w_flush;

    // FSM state and lane counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: walk the lanes in VEC, then let an accepted instruction choose the following mode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            VEC: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: ;
        endcase
        // Accept only happens in RUN or on the last VEC lane, so this overrides the lane walk cleanly.
        if (w_acc) begin
            if (bus.x_isHalt) begin
                w_state_nxt = HALT;
            end else if (!bus.x_taken && bus.x_is_vector_op) begin
                w_state_nxt = VEC;
                w_cnt_nxt   = '0;
            end
        end
    end

    // Capture accepted instruction fields with halt > taken > vector > scalar resolution
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_br      <= 1'b0;
            r_wr      <= 1'b0;
            r_isLd    <= 1'b0;
            r_rt      <= '0;
            r_result  <= '0;
            r_target  <= '0;
            r_vresult <= '0;
        end else begin
            r_valid <= w_acc;
            if (w_acc) begin
                r_br      <= ~bus.x_isHalt & bus.x_taken;
                r_wr      <= ~bus.x_isHalt & ~bus.x_taken & ~bus.x_is_vector_op & bus.x_writes_rt;
                r_isLd    <= bus.x_isLd;
                r_rt      <= bus.x_rt;
                r_result  <= bus.x_result;
                r_target  <= bus.x_target;
                r_vresult <= bus.x_vresult;
            end
        end
    end

    // Select the 16-bit lane addressed by the counter
    always_comb begin
        w_lane_dat = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_cnt == LW'(i)) begin
                w_lane_dat = r_vresult[i*16 +: 16];
            end
        end
    end

    // Scalar port; load data arrives from memory during this writeback cycle, so it stays combinational.
    assign w_reg_wen   = r_valid & r_wr;
    assign w_reg_widx  = w_reg_wen ? r_rt : 4'd0;
    assign w_reg_wdata = w_reg_wen ? (r_isLd ? bus.mem_rdata : r_result) : 16'd0;
    assign w_vec       = (r_state == VEC);

    assign bus.x_stall     = w_stall;
    assign bus.flush       = w_flush;
    assign bus.redirect_pc = w_flush ? r_target : 16'd0;
    assign bus.reg_wen     = w_reg_wen;
    assign bus.reg_widx    = w_reg_widx;
    assign bus.reg_wdata   = w_reg_wdata;
    assign bus.vreg_wen    = w_vec;
    assign bus.vreg_widx   = w_vec ? r_rt : 4'd0;
    assign bus.vreg_lane   = w_vec ? r_cnt : '0;
    assign bus.vreg_wdata  = w_vec ? w_lane_dat : 16'd0;
    assign bus.halted      = (r_state == HALT);

`ifdef WB_FWD_EN
    assign bus.fwd_valid = w_reg_wen;
    assign bus.fwd_idx   = w_reg_widx;
    assign bus.fwd_data  = w_reg_wdata;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed spec scenarios followed by random instruction streams.
// Expected outputs come from a queue of per-cycle writeback records built from each accepted instruction.
// Summary line reports total comparisons and failures.
module tb_wb_stage;
    localparam int LANES = 4;

    logic clk;
    logic rst_n;

    wb_stage_if #(.LANES(LANES)) wbif ();

    wb_stage #(.LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wbif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic [15:0] rpc;
        logic        rwen;
        logic [3:0]  ridx;
        logic [15:0] rdat;
        logic        vwen;
        logic [3:0]  vidx;
        logic [2:0]  lane;
        logic [15:0] vdat;
        logic        halted;
    } out_t;

    typedef struct {
        out_t        o;
        bit          ld;
        logic [15:0] ld_data;
        bit          block;
    } rec_t;

    typedef struct {
        logic [15:0]         pc;
        logic [3:0]          rt;
        logic [15:0]         result;
        logic [15:0]         target;
        logic [15:0]         mdat;
        logic [16*LANES-1:0] vres;
        bit                  ld, vec, halt, wr, taken;
    } ins_t;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    rec_t q[$];
    rec_t cur;
    bit   m_halt = 0;
    bit   have   = 0;
    ins_t pend;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic rec_t idle_rec();
        rec_t r;
        r.o       = '0;
        r.ld      = 0;
        r.ld_data = '0;
        r.block   = 0;
        if (m_halt) begin
            r.o.stall  = 1'b1;
            r.o.halted = 1'b1;
        end
        return r;
    endfunction

    function automatic out_t sample(bit raw);
        out_t s;
        s.stall  = wbif.x_stall;
        s.flush  = wbif.flush;
        s.rpc    = wbif.redirect_pc;
        s.rwen   = wbif.reg_wen;
        s.ridx   = wbif.reg_widx;
        s.rdat   = wbif.reg_wdata;
        s.vwen   = wbif.vreg_wen;
        s.vidx   = wbif.vreg_widx;
        s.lane   = 3'(wbif.vreg_lane);
        s.vdat   = wbif.vreg_wdata;
        s.halted = wbif.halted;
        if (!raw) begin
            if (!s.flush) s.rpc = '0;
            if (!s.rwen) begin s.ridx = '0; s.rdat = '0; end
            if (!s.vwen) begin s.vidx = '0; s.lane = '0; s.vdat = '0; end
        end
        return s;
    endfunction

    // Reference: an accepted instruction becomes the list of cycles it will occupy in writeback.
    function automatic void model_accept(ins_t i);
        rec_t r;
        if (i.halt) begin
            m_halt = 1;
        end else if (i.taken) begin
            r = idle_rec();
            r.o.flush = 1'b1;
            r.o.rpc   = i.target;
            r.block   = 1;
            q.push_back(r);
        end else if (i.vec) begin
            for (int l = 0; l < LANES; l++) begin
                r = idle_rec();
                r.o.vwen  = 1'b1;
                r.o.vidx  = i.rt;
                r.o.lane  = 3'(l);
                r.o.vdat  = i.vres[16*l +: 16];
                r.o.stall = (l != LANES - 1);
                q.push_back(r);
            end
        end else if (i.wr) begin
            r = idle_rec();
            r.o.rwen  = 1'b1;
            r.o.ridx  = i.rt;
            r.o.rdat  = i.ld ? i.mdat : i.result;
            r.ld      = i.ld;
            r.ld_data = i.mdat;
            q.push_back(r);
        end
    endfunction

    function automatic ins_t blank();
        ins_t i;
        i.pc = '0; i.rt = '0; i.result = '0; i.target = '0; i.mdat = '0; i.vres = '0;
        i.ld = 0; i.vec = 0; i.halt = 0; i.wr = 0; i.taken = 0;
        return i;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t i;
        i = blank();
        i.pc     = 16'($urandom);
        i.rt     = 4'($urandom);
        i.result = 16'($urandom);
        i.target = 16'($urandom);
        i.mdat   = 16'($urandom);
        for (int l = 0; l < LANES; l++) i.vres[16*l +: 16] = 16'($urandom);
        i.ld    = ($urandom_range(0, 1) == 1);
        i.wr    = ($urandom_range(0, 3) != 0);
        i.taken = ($urandom_range(0, 5) == 0);
        i.vec   = ($urandom_range(0, 3) == 0);
        return i;
    endfunction

    task automatic drive(ins_t i);
        wbif.x_valid        = 1'b1;
        wbif.x_pc           = i.pc;
        wbif.x_rt           = i.rt;
        wbif.x_result       = i.result;
        wbif.x_vresult      = i.vres;
        wbif.x_isLd         = i.ld;
        wbif.x_is_vector_op = i.vec;
        wbif.x_isHalt       = i.halt;
        wbif.x_writes_rt    = i.wr;
        wbif.x_taken        = i.taken;
        wbif.x_target       = i.target;
    endtask

    task automatic drive_idle();
        ins_t g;
        g = rnd_ins();
        drive(g);
        wbif.x_valid = 1'b0;
    endtask

    // One clock: check this cycle's outputs, then advance the model across the posedge.
    task automatic step(string tag);
        @(negedge clk);
        cyc++;
        wbif.mem_rdata = cur.ld ? cur.ld_data : 16'($urandom);
        if (have) drive(pend); else drive_idle();
        #1 check($sformatf("%s@%0d", tag, cyc), sample(0), cur.o);
        @(posedge clk);
        if (have && !cur.o.stall && !cur.block) begin
            model_accept(pend);
            have = 0;
        end
        if (q.size() > 0) cur = q.pop_front(); else cur = idle_rec();
    endtask

    task automatic issue(string tag, ins_t i);
        int n;
        pend = i;
        have = 1;
        n    = 0;
        while (have && n < 40) begin
            step(tag);
            n++;
        end
        tests++;
        if (have) begin
            fails++;
            $error("FAIL %s_accept_timeout observed=pending expected=accepted", tag);
            have = 0;
        end
    endtask

    task automatic reset_pulse(string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check(tag, sample(1), '0);
        q.delete();
        m_halt = 0;
        have   = 0;
        cur    = idle_rec();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t i;
        rst_n = 1'b0;
        wbif.mem_rdata = '0;
        drive_idle();
        cur = idle_rec();
        repeat (2) @(negedge clk);
        #1 check("reset_outputs", sample(1), '0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset_idle");

        // Scalar ALU write
        i = blank(); i.rt = 4'd3; i.result = 16'h1234; i.wr = 1;
        issue("scalar", i);
        step("scalar_wb");
        // Load write uses memory data in the writeback cycle
        i = blank(); i.rt = 4'd5; i.ld = 1; i.wr = 1; i.result = 16'h0BAD; i.mdat = 16'hBEEF;
        issue("load", i);
        step("load_wb");
        // Vector followed back-to-back by a scalar that must land right after the last lane
        i = blank(); i.rt = 4'd2; i.vec = 1; i.vres = 64'h4444_3333_2222_1111;
        issue("vector", i);
        i = blank(); i.rt = 4'd7; i.result = 16'h7777; i.wr = 1;
        issue("after_vec", i);
        step("after_vec_wb");
        // Branch; the next instruction is refused during the flush cycle
        i = blank(); i.taken = 1; i.target = 16'h0040;
        issue("branch", i);
        i = blank(); i.rt = 4'd9; i.result = 16'h9999; i.wr = 1;
        issue("after_branch", i);
        step("after_branch_wb");
        // Coinciding flags: taken wins over vector and write, vector wins over write
        i = blank(); i.taken = 1; i.vec = 1; i.wr = 1; i.rt = 4'd1; i.target = 16'h0100;
        issue("prio_taken", i);
        step("prio_taken_wb");
        i = blank(); i.vec = 1; i.wr = 1; i.rt = 4'd4; i.result = 16'hDEAD; i.vres = 64'hA0A0_B0B0_C0C0_D0D0;
        issue("prio_vec", i);
        repeat (LANES + 1) step("prio_vec_wb");

        // Random instruction stream with occasional idle gaps
        for (int k = 0; k < 150; k++) begin
            issue("rand", rnd_ins());
            if ($urandom_range(0, 3) == 0) step("rand_gap");
        end
        repeat (LANES + 1) step("rand_drain");

        // Reset mid-vector aborts remaining lanes
        i = blank(); i.rt = 4'd6; i.vec = 1; i.vres = 64'h1357_2468_9ABC_DEF0;
        issue("vec_abort", i);
        step("vec_abort_lane");
        reset_pulse("reset_mid_vec");
        repeat (LANES) step("after_vec_abort");

        // Halt is sticky; a presented instruction is never accepted
        i = blank(); i.halt = 1; i.wr = 1; i.taken = 1; i.rt = 4'd8;
        issue("halt", i);
        pend = rnd_ins();
        have = 1;
        repeat (5) step("halted");
        have = 0;
        reset_pulse("reset_in_halt");
        step("after_halt_reset");
        i = blank(); i.rt = 4'd11; i.result = 16'h0B0B; i.wr = 1;
        issue("resume", i);
        step("resume_wb");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
